// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
//
// Multi-cycle data memory stage placed after the single-cycle datapath. A load
// or store is captured in IDLE, waits LATENCY cycles in BUSY, and completes
// into DONE. The stall output holds the PC from the request cycle through the
// last BUSY cycle.
//
// Parameters
//   ADDR_W   word-index width; memory holds 2^ADDR_W 32-bit words
//   LATENCY  BUSY cycles per access, legal range 1..15
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   mem_read   load request, held for the whole instruction
//   mem_write  store request, held for the whole instruction
//   addr       byte address (datapath alu_out)
//   wdata      store data (datapath register-B output)
//   rdata      load data back to the datapath
//   stall      high while the datapath must hold PC and register writes
//   busy       high whenever the FSM is not in IDLE
//   err        sticky error: misaligned request or read+write together
// -----------------------------------------------------------------------------
module data_mem_unit #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        busy,
  output logic        err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_op_write;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [0:DEPTH-1];

  logic                w_req;
  logic                w_aligned;
  logic                w_start;
  logic                w_set_err;
  logic                w_last;
  logic [ADDR_W-1:0]   w_idx;
  logic                w_unused_addr;

  assign w_req     = mem_read | mem_write;
  assign w_aligned = (addr[1:0] == 2'b00);
  assign w_start   = w_req & w_aligned;
  // Misaligned requests and read+write collisions both flag the error; the
  // collision still proceeds as a write.
  assign w_set_err = w_req & (~w_aligned | (mem_read & mem_write));
  assign w_idx     = addr[ADDR_W+1:2];
  assign w_last    = (r_state == BUSY) && (r_cnt == 4'd0);

  // Upper address bits are deliberately dropped so addresses wrap.
  assign w_unused_addr = ^{addr[31:ADDR_W+2]};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and stall
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // stall must rise in the request cycle itself so the PC does not
        // advance on the capture edge.
        if (w_start) begin
          stall  = 1'b1;
          w_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (r_cnt == 4'd0) w_next = DONE;
      end
      DONE: begin
        // The completing instruction still holds its request here; DONE never
        // re-triggers, the next instruction's request is seen in IDLE.
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy  = (r_state != IDLE);
  assign rdata = r_rdata;
  assign err   = r_err;

  // ---------------------------------------------------------------------------
  // Operand capture, wait counter, read data and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_start) begin
        r_op_write <= mem_write;
        r_idx      <= w_idx;
        r_wdata    <= wdata;
        r_cnt      <= CNT_INIT;
      end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_last && !r_op_write) r_rdata <= r_mem[r_idx];

      if ((r_state == IDLE) && w_set_err) r_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; clearing RAM on reset is not wanted
  // and would prevent mapping onto a memory macro. rst only gates the write
  // so an access aborted on its final BUSY cycle leaves memory untouched.
  always_ff @(posedge clk) begin
    if (w_last && r_op_write && !rst) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_data_mem_unit
//
// Scoreboard bench for data_mem_unit. The driver issues accesses one
// instruction at a time and pushes the expected completion (rdata, err) into a
// queue computed from a word-array model. An independent monitor watches for
// the DONE cycle (busy high, stall low), pops and compares, checks that every
// stall run lasts LATENCY+1 cycles, and checks rdata holds while idle.
// -----------------------------------------------------------------------------
module tb_data_mem_unit;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 2;
  localparam int WORDS   = 1 << ADDR_W;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        busy;
  logic        err;

  data_mem_unit #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [WORDS];
  logic [31:0] m_rdata;
  logic        m_err;

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd4) % WORDS);
  endfunction

  // One instruction. Starts and ends at posedge+1.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    if (a % 4 != 0) begin
      m_err = 1'b1;
      @(negedge clk);
      check("misaligned_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      check("misaligned_err", {31'd0, err}, 32'd1);
      check("misaligned_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end else begin
      if (wr) begin
        m_mem[word_of(a)] = d;
        if (rd) m_err = 1'b1;
      end else begin
        m_rdata = m_mem[word_of(a)];
      end
      sb_q.push_back('{rdata: m_rdata, err: m_err});
      @(posedge clk); #1;
      // Operands change mid-flight; the captured copies must be used.
      addr  = $urandom;
      wdata = $urandom;
      repeat (LATENCY + 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int          stall_run  = 0;
  logic [31:0] last_rdata = 32'd0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      stall_run  = 0;
      last_rdata = 32'd0;
    end else begin
      if (stall === 1'b1) begin
        stall_run++;
      end else begin
        if (stall_run > 0) check("stall_length", 32'(stall_run), 32'(LATENCY + 1));
        stall_run = 0;
      end
      if (busy === 1'b1 && stall === 1'b0) begin
        if (sb_q.size() == 0) begin
          check("done_without_request", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_rdata", rdata, e.rdata);
          check("done_err", {31'd0, err}, {31'd0, e.err});
          last_rdata = e.rdata;
        end
      end else if (busy === 1'b0) begin
        check("rdata_hold", rdata, last_rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    m_rdata   = 32'd0;
    m_err     = 1'b0;

    // Reset with no requests.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_rdata", rdata, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Give every location in the working pool a known value.
    for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom);

    // Store then load.
    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 32'h10, 32'd0);
    idle(3);

    // Address wrap-around.
    issue(1'b0, 1'b1, 32'h404, 32'h12345678);
    issue(1'b1, 1'b0, 32'h004, 32'd0);

    // Misaligned read; err must stay set through later good accesses.
    issue(1'b1, 1'b0, 32'h13, 32'd0);
    issue(1'b1, 1'b0, 32'h10, 32'd0);
    issue(1'b0, 1'b1, 32'h18, 32'h0BADF00D);

    // Back-to-back read then write then read.
    issue(1'b1, 1'b0, 32'h10, 32'd0);
    issue(1'b0, 1'b1, 32'h14, 32'hCAFE0014);
    issue(1'b1, 1'b0, 32'h14, 32'd0);

    // Abort a write with reset in its first BUSY cycle.
    issue(1'b0, 1'b1, 32'h20, 32'h11111111);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    addr      = 32'h20;
    wdata     = 32'hAAAA5555;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_write = 1'b0;
    m_err     = 1'b0;
    m_rdata   = 32'd0;
    @(negedge clk);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h20, 32'd0);

    // Randomized traffic over a 16-word pool with random upper address bits.
    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 15);
      a    = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      if (kind == 0) a = a | 32'($urandom_range(1, 3));
      if (kind == 15)     idle($urandom_range(1, 3));
      else if (kind == 14) issue(1'b1, 1'b1, a, $urandom);
      else if (kind < 7)   issue(1'b1, 1'b0, a, $urandom);
      else                 issue(1'b0, 1'b1, a, $urandom);
    end

    idle(4);
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Multi-cycle data memory stage sitting directly downstream of the single-cycle datapath.
- Consumes the datapath's ALU result as the byte address and its register-B output as the store data.
- Returns load data to the datapath's data_in input.
- Drives a stall signal that holds the PC enable low while an access with wait states is in flight.

Parameters:
- ADDR_W, 8, word-index width; memory depth is 2^ADDR_W 32-bit words.
- LATENCY, 2, wait cycles in BUSY per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  load request from control; held for the whole instruction.
- mem_write  input  1  store request from control; held for the whole instruction.
- addr  input  32  byte address (datapath alu_out).
- wdata  input  32  store data (datapath data_out).
- rdata  output  32  load data to datapath data_in.
- stall  output  1  high = datapath must hold PC and register writes.
- busy  output  1  high when state is not IDLE.
- err  output  1  sticky error flag.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - After reset: state=IDLE, cnt=0, rdata=0, err=0, stall=0, busy=0.
  - Memory array contents are not cleared by rst.
- Request: req = mem_read | mem_write.
  - Word index = addr[ADDR_W+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_W bytes.
- Misaligned request: addr[1:0] != 0 is a bad request.
  - No access occurs, stall stays 0, state stays IDLE.
  - err is set to 1 at that edge and stays set until rst.
- Simultaneous mem_read and mem_write: the request is treated as a write, and err is set at the IDLE edge.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned req: stall=1 combinationally in this cycle. At the edge, capture op, word index and wdata; load cnt=LATENCY-1; go to BUSY.
  - IDLE, no req or bad req: stay in IDLE, stall=0.
  - BUSY: stall=1.
    - If cnt==0, perform the access at the edge and go to DONE. A write stores wdata_q to mem[idx_q]; a read loads rdata<=mem[idx_q].
    - Otherwise decrement cnt.
  - DONE: stall=0. The datapath advances the PC at this edge. Always return to IDLE.
  - DONE never re-triggers, even though mem_read/mem_write are still high for the completing instruction.
- Timing:
  - stall is high for exactly LATENCY+1 consecutive cycles per access: the IDLE request cycle plus LATENCY BUSY cycles.
  - An access occupies LATENCY+2 cycles in total.
  - New read data is visible on rdata in the DONE cycle.
- Output rules:
  - busy = (state != IDLE).
  - stall = (IDLE & aligned req) | BUSY. The combinational path from req to stall is required so the PC does not advance on the request edge.
  - rdata holds its last loaded value until the next read completes; writes never change rdata.
- Captured operands: addr and wdata changes after the IDLE capture edge have no effect on the in-flight access.
- Back-to-back accesses: a request present in the cycle after DONE (next instruction) starts a new access from IDLE with no bubble cycle.
- Reset mid-operation: rst in BUSY or DONE aborts the access. A pending write is discarded (memory unchanged), and the block returns to the IDLE/reset output values at that edge.
- LATENCY=1: BUSY lasts exactly one cycle.

Test Plan:
- Reset then idle: rst high 2 cycles, no req -> rdata=0, err=0, stall=0, busy=0 on every cycle.
- Store then load, LATENCY=2:
  - write addr=0x10, wdata=0xDEADBEEF -> stall high 3 cycles, DONE on cycle 4.
  - Then read addr=0x10 -> rdata=0xDEADBEEF in the DONE cycle, held afterwards.
- Wrap-around, ADDR_W=8: write 0x12345678 to addr=0x404 -> read of addr=0x004 returns 0x12345678.
- Misaligned: read addr=0x13 -> stall stays 0, err=1 from the next cycle, and it remains 1 after later good accesses until rst.
- Abort: start write addr=0x20, wdata=0xAAAA5555 over prior content 0x11111111, assert rst in the first BUSY cycle -> next cycle IDLE with stall=0; a following read of 0x20 returns 0x11111111.
- Back-to-back plus operand change: read 0x10 immediately followed by write 0x14.
  - Second request starts the cycle after DONE, with stall low only in the DONE cycle.
  - Changing addr during BUSY of the first access does not alter its result.
